// File: rtl/rect_source_sequencer.sv
// Rectangular/pulse source sequencer: produces a sampled amplitude code that
// walks delay, linear rise, high plateau, linear fall and low plateau.
// Configuration arrives through a single shadow register. It is promoted to
// the active set while idle, or at a period boundary while running.
module rect_source_sequencer #(
    parameter int DW      = 16,
    parameter int CW      = 24,
    parameter int LW      = 4,
    parameter int MAX_LOG = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [DW-1:0] cfg_iv,
    input  logic [DW-1:0] cfg_pv,
    input  logic [CW-1:0] cfg_td,
    input  logic [CW-1:0] cfg_th,
    input  logic [CW-1:0] cfg_tl,
    input  logic [LW-1:0] cfg_tr_log2,
    input  logic [LW-1:0] cfg_tf_log2,
    input  logic          cfg_oneshot,
    output logic [DW-1:0] level,
    output logic [2:0]    phase,
    output logic          busy,
    output logic          period_strobe
);
    // state  | meaning
    // IDLE   | stopped, level = iv
    // DELAY  | initial delay after start, level = iv
    // RISE   | linear ramp iv -> pv over 2^tr cycles
    // HIGH   | plateau at pv
    // FALL   | linear ramp pv -> iv over 2^tf cycles
    // LOW    | plateau at iv, then the next period starts
    // DONE   | one-shot finished, level = iv
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DELAY = 3'd1,
        S_RISE  = 3'd2,
        S_HIGH  = 3'd3,
        S_FALL  = 3'd4,
        S_LOW   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    typedef struct packed {
        logic [DW-1:0] iv;
        logic [DW-1:0] pv;
        logic [CW-1:0] td;
        logic [CW-1:0] th;
        logic [CW-1:0] tl;
        logic [LW-1:0] tr;
        logic [LW-1:0] tf;
        logic          os;
    } cfg_t;

    localparam int PW = DW + 1 + MAX_LOG;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    cfg_t                 act_q, act_d, sh_q, sh_d, sh_clamped;
    logic                 pending_q, pending_d;
    logic [DW-1:0]        level_q, level_d;
    logic                 strobe_q, strobe_d;
    logic                 accept, apply_idle, apply_run;
    logic [CW-1:0]        start_td;
    logic [DW-1:0]        ramp_from, ramp_to, ramp_level;
    logic [LW-1:0]        ramp_log;
    logic [CW-1:0]        ramp_len_m1;
    logic [MAX_LOG-1:0]   ramp_k;
    logic signed [DW:0]   ramp_diff;
    logic signed [PW-1:0] ramp_prod, ramp_step;

    function automatic logic [LW-1:0] clamp_log(input logic [LW-1:0] v);
        if (int'(v) > MAX_LOG) return LW'(MAX_LOG);
        return v;
    endfunction

    assign cfg_ready     = !pending_q;
    assign level         = level_q;
    assign phase         = state_q;
    assign period_strobe = strobe_q;
    assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);

    // Next-state, config promotion, phase counter and amplitude computation.
    always_comb begin
        accept     = cfg_valid && !pending_q;
        sh_d       = sh_q;
        if (accept) begin
            sh_d = '{iv: cfg_iv, pv: cfg_pv, td: cfg_td, th: cfg_th, tl: cfg_tl,
                     tr: cfg_tr_log2, tf: cfg_tf_log2, os: cfg_oneshot};
        end
        sh_clamped    = sh_q;
        sh_clamped.tr = clamp_log(sh_q.tr);
        sh_clamped.tf = clamp_log(sh_q.tf);

        apply_idle = pending_q && ((state_q == S_IDLE) || (state_q == S_DONE));
        start_td   = apply_idle ? sh_q.td : act_q.td;

        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (start) state_d = (start_td != '0) ? S_DELAY : S_RISE;
            S_DELAY:        if (cnt_q == '0) state_d = S_RISE;
            S_RISE:         if (cnt_q == '0) state_d = (act_q.th != '0) ? S_HIGH : S_FALL;
            S_HIGH:         if (cnt_q == '0) state_d = S_FALL;
            S_FALL: begin
                if (cnt_q == '0) begin
                    if (act_q.os)             state_d = S_DONE;
                    else if (act_q.tl != '0)  state_d = S_LOW;
                    else                      state_d = S_RISE;
                end
            end
            S_LOW:          if (cnt_q == '0) state_d = S_RISE;
            default:        state_d = S_IDLE;
        endcase
        if (stop) state_d = S_IDLE;

        // A running config change lands only where a new period begins.
        apply_run = pending_q && (state_d == S_RISE) &&
                    ((state_q == S_LOW) || (state_q == S_FALL));
        act_d     = (apply_idle || apply_run) ? sh_clamped : act_q;
        pending_d = accept ? 1'b1 : ((apply_idle || apply_run) ? 1'b0 : pending_q);

        cnt_d = cnt_q;
        if (state_d != state_q) begin
            unique case (state_d)
                S_DELAY: cnt_d = act_d.td - CW'(1);
                S_RISE:  cnt_d = (CW'(1) << act_d.tr) - CW'(1);
                S_HIGH:  cnt_d = act_d.th - CW'(1);
                S_FALL:  cnt_d = (CW'(1) << act_d.tf) - CW'(1);
                S_LOW:   cnt_d = act_d.tl - CW'(1);
                default: cnt_d = '0;
            endcase
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end

        // Ramp uses the down-counter to recover the 0-based cycle index k.
        if (state_d == S_FALL) begin
            ramp_from = act_d.pv;
            ramp_to   = act_d.iv;
            ramp_log  = act_d.tf;
        end else begin
            ramp_from = act_d.iv;
            ramp_to   = act_d.pv;
            ramp_log  = act_d.tr;
        end
        ramp_len_m1 = (CW'(1) << ramp_log) - CW'(1);
        ramp_k      = MAX_LOG'(ramp_len_m1 - cnt_d);
        ramp_diff   = $signed({ramp_to[DW-1], ramp_to}) - $signed({ramp_from[DW-1], ramp_from});
        ramp_prod   = $signed({{MAX_LOG{ramp_diff[DW]}}, ramp_diff}) *
                      $signed({{(DW+1){1'b0}}, ramp_k});
        ramp_step   = ramp_prod >>> ramp_log;
        ramp_level  = ramp_from + DW'(ramp_step);

        unique case (state_d)
            S_RISE, S_FALL: level_d = ramp_level;
            S_HIGH:         level_d = act_d.pv;
            default:        level_d = act_d.iv;
        endcase

        strobe_d = ((state_d == S_RISE) && ((state_q == S_LOW) || (state_q == S_FALL))) ||
                   ((state_d == S_DONE) && (state_q == S_FALL));
    end

    // State, counter, config and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            act_q     <= '0;
            sh_q      <= '0;
            pending_q <= 1'b0;
            level_q   <= '0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            act_q     <= act_d;
            sh_q      <= sh_d;
            pending_q <= pending_d;
            level_q   <= level_d;
            strobe_q  <= strobe_d;
        end
    end

endmodule

// File: tb/tb_rect_source_sequencer.sv
// Directed bench for rect_source_sequencer: a per-cycle vector table plus a
// hand-written asynchronous reset sequence.
module tb_rect_source_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] cfg_iv = '0;
    logic [15:0] cfg_pv = '0;
    logic [23:0] cfg_td = '0;
    logic [23:0] cfg_th = '0;
    logic [23:0] cfg_tl = '0;
    logic [3:0]  cfg_tr_log2 = '0;
    logic [3:0]  cfg_tf_log2 = '0;
    logic        cfg_oneshot = 1'b0;
    logic [15:0] level;
    logic [2:0]  phase;
    logic        busy;
    logic        period_strobe;

    int tests = 0;
    int fails = 0;

    localparam int PI = 0, PD = 1, PR = 2, PH = 3, PF = 4, PL = 5, PN = 6;

    typedef struct {
        int iv; int pv; int td; int th; int tl; int tr; int tf; bit os;
    } tcfg_t;

    typedef struct {
        bit st; bit sp; bit cv; int cs;
        int lvl; int ph; bit b; bit s; bit r;
    } vec_t;

    tcfg_t cfgs[6];
    vec_t  vecs[$];

    rect_source_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_iv(cfg_iv), .cfg_pv(cfg_pv), .cfg_td(cfg_td), .cfg_th(cfg_th),
        .cfg_tl(cfg_tl), .cfg_tr_log2(cfg_tr_log2), .cfg_tf_log2(cfg_tf_log2),
        .cfg_oneshot(cfg_oneshot), .level(level), .phase(phase), .busy(busy),
        .period_strobe(period_strobe)
    );

    always #5 clk = ~clk;

    task automatic add(input bit st, input bit sp, input bit cv, input int cs,
                       input int lvl, input int ph, input bit b, input bit s, input bit r);
        vec_t v;
        v = '{st: st, sp: sp, cv: cv, cs: cs, lvl: lvl, ph: ph, b: b, s: s, r: r};
        vecs.push_back(v);
    endtask

    task automatic drive_cfg(input int cs);
        tcfg_t c;
        c = cfgs[cs];
        cfg_iv      = c.iv[15:0];
        cfg_pv      = c.pv[15:0];
        cfg_td      = c.td[23:0];
        cfg_th      = c.th[23:0];
        cfg_tl      = c.tl[23:0];
        cfg_tr_log2 = c.tr[3:0];
        cfg_tf_log2 = c.tf[3:0];
        cfg_oneshot = c.os;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int lvl, input int ph,
                         input bit b, input bit s, input bit r);
        logic [15:0] el;
        logic [2:0]  ep;
        el = lvl[15:0];
        ep = ph[2:0];
        tests++;
        if (level !== el || phase !== ep || busy !== b || period_strobe !== s || cfg_ready !== r) begin
            fails++;
            $display("FAIL %s: got level=%0d phase=%0d busy=%0b strobe=%0b ready=%0b, expected level=%0d phase=%0d busy=%0b strobe=%0b ready=%0b",
                     nm, $signed(level), phase, busy, period_strobe, cfg_ready, lvl, ph, b, s, r);
        end
    endtask

    initial begin
        //          iv   pv    td th tl tr  tf os
        cfgs[0] = '{0,   0,    0, 0, 0, 0,  0, 1'b0};
        cfgs[1] = '{0,   100,  2, 3, 2, 2,  1, 1'b0};
        cfgs[2] = '{0,   200,  2, 3, 2, 2,  1, 1'b0};
        cfgs[3] = '{10,  -7,   0, 1, 0, 1,  0, 1'b1};
        cfgs[4] = '{-3,  40,   0, 0, 0, 0,  0, 1'b0};
        cfgs[5] = '{0,   4096, 0, 0, 0, 15, 0, 1'b0};

        // continuous run, shadow update during HIGH
        add(0,0,1,1,   0,PI,0,0,0);
        add(0,0,0,0,   0,PI,0,0,1);
        add(1,0,0,0,   0,PD,1,0,1);
        add(0,0,0,0,   0,PD,1,0,1);
        add(0,0,0,0,   0,PR,1,0,1);
        add(0,0,0,0,  25,PR,1,0,1);
        add(0,0,0,0,  50,PR,1,0,1);
        add(0,0,0,0,  75,PR,1,0,1);
        add(0,0,0,0, 100,PH,1,0,1);
        add(0,0,1,2, 100,PH,1,0,0);
        add(0,0,0,0, 100,PH,1,0,0);
        add(0,0,0,0, 100,PF,1,0,0);
        add(0,0,0,0,  50,PF,1,0,0);
        add(0,0,0,0,   0,PL,1,0,0);
        add(0,0,0,0,   0,PL,1,0,0);
        add(0,0,0,0,   0,PR,1,1,1);
        add(0,0,0,0,  50,PR,1,0,1);
        add(0,0,0,0, 100,PR,1,0,1);
        add(0,0,0,0, 150,PR,1,0,1);
        add(0,0,0,0, 200,PH,1,0,1);
        add(0,0,0,0, 200,PH,1,0,1);
        add(0,0,0,0, 200,PH,1,0,1);
        add(0,0,0,0, 200,PF,1,0,1);
        add(0,0,0,0, 100,PF,1,0,1);
        add(0,0,0,0,   0,PL,1,0,1);
        add(0,0,0,0,   0,PL,1,0,1);
        add(0,0,0,0,   0,PR,1,1,1);
        add(0,0,0,0,  50,PR,1,0,1);
        // stop+start mid-RISE, then start while busy
        add(1,1,0,0,   0,PI,0,0,1);
        add(1,0,0,0,   0,PD,1,0,1);
        add(1,0,0,0,   0,PD,1,0,1);
        add(1,0,0,0,   0,PR,1,0,1);
        add(0,0,0,0,  50,PR,1,0,1);
        add(0,1,0,0,   0,PI,0,0,1);
        // signed floor rounding, one-shot, restart from DONE
        add(0,0,1,3,   0,PI,0,0,0);
        add(0,0,0,0,  10,PI,0,0,1);
        add(1,0,0,0,  10,PR,1,0,1);
        add(0,0,0,0,   1,PR,1,0,1);
        add(0,0,0,0,  -7,PH,1,0,1);
        add(0,0,0,0,  -7,PF,1,0,1);
        add(0,0,0,0,  10,PN,0,1,1);
        add(0,0,0,0,  10,PN,0,0,1);
        add(1,0,0,0,  10,PR,1,0,1);
        add(0,0,0,0,   1,PR,1,0,1);
        add(0,0,0,0,  -7,PH,1,0,1);
        add(0,0,0,0,  -7,PF,1,0,1);
        add(0,0,0,0,  10,PN,0,1,1);
        // zero-length phases
        add(0,0,1,4,  10,PN,0,0,0);
        add(0,0,0,0,  -3,PN,0,0,1);
        add(1,0,0,0,  -3,PR,1,0,1);
        add(0,0,0,0,  40,PF,1,0,1);
        add(0,0,0,0,  -3,PR,1,1,1);
        add(0,0,0,0,  40,PF,1,0,1);
        add(0,0,0,0,  -3,PR,1,1,1);
        add(0,1,0,0,  -3,PI,0,0,1);
        // rise exponent 15 clamps to 12
        add(0,0,1,5,  -3,PI,0,0,0);
        add(0,0,0,0,   0,PI,0,0,1);
        add(1,0,0,0,   0,PR,1,0,1);
        add(0,0,0,0,   1,PR,1,0,1);
        add(0,0,0,0,   2,PR,1,0,1);
        add(0,0,0,0,   3,PR,1,0,1);
        add(0,1,0,0,   0,PI,0,0,1);

        #12;
        check("reset_state", 0, PI, 0, 0, 1);
        #11 rst_n = 1'b1;
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            start     = vecs[i].st;
            stop      = vecs[i].sp;
            cfg_valid = vecs[i].cv;
            drive_cfg(vecs[i].cs);
            step();
            check($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].ph, vecs[i].b, vecs[i].s, vecs[i].r);
        end
        start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;

        // asynchronous reset mid-HIGH with a pending shadow
        cfg_valid = 1'b1; drive_cfg(1); step();
        cfg_valid = 1'b0; step();
        start = 1'b1; step();
        start = 1'b0;
        repeat (6) step();
        check("rst_pre_high", 100, PH, 1, 0, 1);
        cfg_valid = 1'b1; drive_cfg(2); step();
        cfg_valid = 1'b0;
        check("rst_pending", 100, PH, 1, 0, 0);
        #3 rst_n = 1'b0;
        #1 check("rst_async", 0, PI, 0, 0, 1);
        step();
        check("rst_hold", 0, PI, 0, 0, 1);
        #3 rst_n = 1'b1;
        start = 1'b1; step();
        start = 1'b0;
        check("rst_run_rise", 0, PR, 1, 0, 1);
        step();
        check("rst_run_fall", 0, PF, 1, 0, 1);
        step();
        check("rst_run_rise2", 0, PR, 1, 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rect_source_sequencer.md
Name: rect_source_sequencer

Overview:
- Clocked digital sequencer that drives the amplitude code of a rectangular/pulse current or voltage source.
- Each period runs delay, linear rise, high plateau, linear fall and low plateau. It replaces analog pulse-source behaviour where a sampled digital drive is needed.
- Programmed through a shadowed config handshake. Supports continuous (rect) and one-shot (pulse) modes.

Parameters:
DW, 16, signed width of level codes (iv, pv, level)
CW, 24, unsigned width of phase duration counts (td, th, tl)
LW, 4, width of rise/fall log2 fields
MAX_LOG, 12, maximum ramp exponent; larger requests clamp to this

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  arm/run request, single-cycle sample
stop  in  1  abort request
cfg_valid  in  1  shadow config offered
cfg_ready  out  1  shadow register free
cfg_iv  in  DW  initial/low level (signed)
cfg_pv  in  DW  pulse/high level (signed)
cfg_td  in  CW  delay ticks (first period only)
cfg_th  in  CW  high plateau ticks
cfg_tl  in  CW  low plateau ticks
cfg_tr_log2  in  LW  rise length = 2^n ticks
cfg_tf_log2  in  LW  fall length = 2^n ticks
cfg_oneshot  in  1  1 = single pulse then DONE
level  out  DW  signed amplitude code, registered
phase  out  3  IDLE=0 DELAY=1 RISE=2 HIGH=3 FALL=4 LOW=5 DONE=6
busy  out  1  high in DELAY..LOW
period_strobe  out  1  one-cycle pulse on period completion

Behaviour:
- Reset values:
  - level=0, phase=IDLE, busy=0, period_strobe=0, cfg_ready=1.
  - Active and shadow config all zero; pending=0.
- Config handshake:
  - cfg_ready = !pending. Accept on cfg_valid&&cfg_ready: load shadow, set pending.
  - Shadow is copied to active and pending cleared at these points:
    - In IDLE/DONE: the cycle after accept.
    - When running: at the period boundary, i.e. the transition into RISE from LOW, or from FALL when tl=0. Never mid-period.
  - Log2 fields above MAX_LOG clamp to MAX_LOG when applied.
- start sampled high in IDLE/DONE:
  - The next cycle enters DELAY, or RISE if td=0.
  - If a shadow is applied in that same cycle, the new config governs.
  - start while busy is ignored.
- Phase durations, exact in cycles:
  - DELAY=td, HIGH=th, LOW=tl. A zero count skips the phase, with the transition taken directly to the following phase.
  - RISE=2^tr_log2, FALL=2^tf_log2 (minimum 1).
  - DELAY occurs only after start, not in later periods.
- Transitions:
  - DELAY→RISE→HIGH→FALL→LOW→RISE (continuous).
  - oneshot: FALL→DONE.
  - A single down-counter is reloaded on each phase entry.
- Level per cycle (k = 0-based cycle index within the phase):
  - IDLE/DONE/DELAY/LOW: level=iv.
  - HIGH: level=pv.
  - RISE: iv + (((pv−iv)·k) >>> tr_log2).
  - FALL: pv + (((iv−pv)·k) >>> tf_log2).
  - Difference uses DW+1 bits; product uses DW+1+MAX_LOG bits. Arithmetic shift (floor rounding); the result always lies between iv and pv, so no overflow.
- period_strobe:
  - High for exactly one cycle: the first RISE cycle of each new period (not the first after DELAY).
  - In oneshot mode: the first DONE cycle.
- stop:
  - Any state → IDLE the next cycle; level=active iv; busy=0; no strobe.
  - stop and start in the same cycle: stop wins.
  - A pending shadow applies in the following cycle, per the IDLE rule.
- rst_n asserted mid-operation: all outputs and state return to reset values asynchronously; the pending shadow is discarded.

Test Plan:
1. Continuous run:
   - Stimulus: cfg iv=0, pv=100, td=2, tr_log2=2, th=3, tf_log2=1, tl=2; start.
   - Required: level 0,0 | 0,25,50,75 | 100,100,100 | 100,50 | 0,0 | then RISE 0,25,… with no DELAY; period_strobe on that RISE's first cycle.
2. Signed floor rounding:
   - Stimulus: iv=10, pv=−7, tr_log2=1, th=1, tf_log2=0, tl=0, oneshot; start.
   - Required: RISE 10,1; HIGH −7; FALL −7; DONE 10 with strobe; busy falls.
3. Shadow update mid-period:
   - Stimulus: during HIGH of test 1, offer pv=200.
   - Required: cfg_ready drops next cycle; current FALL still ramps from 100; the next RISE ramps 0,50,100,150; cfg_ready returns high at the boundary.
4. Zero-length phases:
   - Stimulus: td=0, th=0, tl=0, tr_log2=0, tf_log2=0, continuous.
   - Required: phase alternates RISE,FALL; level iv,pv repeating; strobe every 2 cycles.
5. Abort and priority:
   - Stimulus: stop+start together mid-RISE.
   - Required: IDLE next cycle, level=iv; start asserted later while busy has no effect.
6. Async reset:
   - Stimulus: rst_n low mid-HIGH, with a pending shadow.
   - Required: immediately level=0, phase=0, cfg_ready=1; after release, start runs with zero config (level stays 0).
